alu_result_display: RTL

- Downstream stage of the 4-bit switch ALU.
- Captures one ALU result record (result nibble, flags, function code) through a valid/ready handshake.
- Renders the record on a 4-digit, time-multiplexed, common-anode 7-segment display: signed magnitude for add/sub, hex for everything else, blinking 'E' on signed overflow.
- Enforces a minimum display hold time so fast switch changes stay readable.

---
 rtl/alu_result_display_if.sv | 12 +
 rtl/alu_result_display.sv | 91 +++++++++
 2 files changed

// File: rtl/alu_result_display_if.sv
// alu_result_display_if: valid/ready channel carrying one ALU result record
interface alu_result_display_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_res;
  logic       in_cout;
  logic       in_ovf;
  logic       in_zero;
  logic [2:0] in_func;
  modport master(output in_valid, in_res, in_cout, in_ovf, in_zero, in_func, input in_ready);
  modport slave(input in_valid, in_res, in_cout, in_ovf, in_zero, in_func, output in_ready);
endinterface

// File: rtl/alu_result_display.sv
// alu_result_display: latches an ALU record and scans it onto a 4-digit common-anode 7-segment display
module alu_result_display #(
  parameter int SCAN_DIV  = 50000,
  parameter int HOLD_CYC  = 5000000,
  parameter int BLINK_DIV = 12500000
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_result_display_if.slave  bus,
  output logic [3:0]           seg_an,
  output logic [7:0]           seg_out,
  output logic [2:0]           led_flags
);
  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam logic [7:0] FONT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };
  typedef enum logic [1:0] {RESET, IDLE, HOLD} state_t;
  state_t          state_q, state_d;
  logic [SW-1:0]   scan_cnt_q, scan_cnt_d;
  logic [1:0]      digit_idx_q, digit_idx_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            blink_on_q, blink_on_d;
  logic [3:0]      res_q, res_d;
  logic [2:0]      func_q, func_d;
  logic [2:0]      flags_q, flags_d;
  logic [3:0]      seg_an_q, seg_an_d;
  logic [7:0]      seg_out_q, seg_out_d;
  logic            accept, hold_last, scan_wrap, blink_wrap, is_signed, neg;
  logic [3:0]      mag;
  assign bus.in_ready = state_q == IDLE;
  assign seg_an       = seg_an_q;
  assign seg_out      = seg_out_q;
  assign led_flags    = flags_q;
  always_comb begin
    accept      = bus.in_valid && state_q == IDLE;
    hold_last   = hold_cnt_q == HW'(HOLD_CYC - 1);
    scan_wrap   = scan_cnt_q == SW'(SCAN_DIV - 1);
    blink_wrap  = blink_cnt_q == BW'(BLINK_DIV - 1);
    state_d     = state_q == RESET ? IDLE :
                  state_q == IDLE  ? (accept ? HOLD : IDLE) :
                  (hold_last ? IDLE : HOLD);
    hold_cnt_d  = state_q == HOLD && !hold_last ? hold_cnt_q + 1'b1 : '0;
    scan_cnt_d  = scan_wrap ? '0 : scan_cnt_q + 1'b1;
    digit_idx_d = scan_wrap ? digit_idx_q + 2'd1 : digit_idx_q;
    blink_cnt_d = accept || blink_wrap ? '0 : blink_cnt_q + 1'b1;
    blink_on_d  = accept ? 1'b1 : blink_on_q ^ blink_wrap;
    res_d       = accept ? bus.in_res : res_q;
    func_d      = accept ? bus.in_func : func_q;
    flags_d     = accept ? {bus.in_ovf, bus.in_cout, bus.in_zero} : flags_q;
    is_signed   = func_q[2:1] == 2'b00;
    neg         = is_signed && res_q[3];
    mag         = neg ? ~res_q + 4'd1 : res_q;
    seg_an_d    = ~(4'd1 << digit_idx_q);
    seg_out_d   = digit_idx_q == 2'd0 ? FONT[mag] :
                  digit_idx_q == 2'd1 ? (neg ? 8'hBF : 8'hFF) :
                  digit_idx_q == 2'd2 ? FONT[{1'b0, func_q}] :
                  (is_signed && flags_q[2] && blink_on_q ? 8'h86 : 8'hFF);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= RESET;
      scan_cnt_q  <= '0;
      digit_idx_q <= '0;
      hold_cnt_q  <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      res_q       <= '0;
      func_q      <= '0;
      flags_q     <= '0;
      seg_an_q    <= 4'hF;
      seg_out_q   <= 8'hFF;
    end else begin
      state_q     <= state_d;
      scan_cnt_q  <= scan_cnt_d;
      digit_idx_q <= digit_idx_d;
      hold_cnt_q  <= hold_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      res_q       <= res_d;
      func_q      <= func_d;
      flags_q     <= flags_d;
      seg_an_q    <= seg_an_d;
      seg_out_q   <= seg_out_d;
    end
  end
endmodule
